bp_perf_monitor: RTL and testbench

BP_PERF_MONITOR -- requirements
Module: bp_perf_monitor

---
 rtl/bp_perf_pkg.sv | 15 +
 rtl/sat_counter.sv | 30 +++
 rtl/bp_perf_monitor.sv | 172 +++++++++++++++++
 tb/tb_bp_perf_monitor.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bp_perf_pkg.sv
// Shared definitions for the branch-predictor performance monitor.
package bp_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 8;
  localparam int CNT_W_MIN  = 8;
  localparam int CNT_W_MAX  = 48;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] q_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/bp_perf_monitor.sv
// Per-channel branch/mispredict totals plus windowed reports with a
// valid/ready handshake.  state | meaning: IDLE idle, RUN counting, HOLD report pending.
module bp_perf_monitor
  import bp_perf_pkg::*;
#(
  parameter int              NUM_CH = 2,
  parameter int              CNT_W  = 32,
  parameter longint unsigned WINDOW = 1024,
  localparam int             RD_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    instr_vld_i,
  input  logic [NUM_CH-1:0]       br_instr_i,
  input  logic [NUM_CH-1:0]       br_miss_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    clear_i,
  input  logic [RD_W-1:0]         rd_ch_i,
  output logic [CNT_W-1:0]        tot_br_o,
  output logic [CNT_W-1:0]        tot_miss_o,
  output logic [CNT_W-1:0]        tot_instr_o,
  output logic                    rpt_vld_o,
  input  logic                    rpt_rdy_i,
  output logic [NUM_CH*CNT_W-1:0] rpt_br_o,
  output logic [NUM_CH*CNT_W-1:0] rpt_miss_o,
  output logic                    rpt_ovf_o,
  output logic                    err_o
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX || CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX)
  begin : g_bad_param
    $error("bp_perf_monitor: NUM_CH or CNT_W out of range");
  end

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  // Single-stage release sync: assertion stays asynchronous, release is clocked.
  logic rst_sync_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= 1'b0;
    else         rst_sync_q <= 1'b1;
  end

  state_e state_q, state_d;
  logic   rpt_vld_q, rpt_vld_d;
  logic   ovf_q, err_q;
  logic [NUM_CH*CNT_W-1:0] rpt_br_q, rpt_miss_q, snap_br, snap_miss;
  logic [CNT_W-1:0] tot_br_q, tot_miss_q, tot_instr_q, rd_br_d, rd_miss_d;

  logic              counting, instr_inc, win_end, accept, load, ovf_set, proto_err;
  logic [NUM_CH-1:0] br_inc, miss_inc;
  logic [CNT_W-1:0]  tot_instr, win_instr;
  logic [CNT_W-1:0]  tot_br [NUM_CH];
  logic [CNT_W-1:0]  tot_miss [NUM_CH];
  logic [CNT_W-1:0]  win_br [NUM_CH];
  logic [CNT_W-1:0]  win_miss [NUM_CH];

  assign counting  = (state_q != ST_IDLE);
  assign instr_inc = counting & instr_vld_i;
  assign br_inc    = counting ? br_instr_i : '0;
  assign miss_inc  = br_inc & br_miss_i;
  assign proto_err = counting & (|(br_miss_i & ~br_instr_i));
  assign win_end   = instr_inc & (win_instr == WIN_LAST);
  assign accept    = rpt_vld_q & rpt_rdy_i;
  assign load      = win_end & ~clear_i & (~rpt_vld_q | rpt_rdy_i);
  assign ovf_set   = win_end & rpt_vld_q & ~rpt_rdy_i;

  sat_counter #(.CNT_W(CNT_W)) u_tot_instr (
    .clk_i(clk_i), .rst_ni(rst_sync_q), .inc_i(instr_inc), .clr_i(clear_i), .q_o(tot_instr)
  );
  sat_counter #(.CNT_W(CNT_W)) u_win_instr (
    .clk_i(clk_i), .rst_ni(rst_sync_q), .inc_i(instr_inc), .clr_i(clear_i | win_end),
    .q_o(win_instr)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sat_counter #(.CNT_W(CNT_W)) u_tot_br (
      .clk_i(clk_i), .rst_ni(rst_sync_q), .inc_i(br_inc[c]), .clr_i(clear_i), .q_o(tot_br[c])
    );
    sat_counter #(.CNT_W(CNT_W)) u_tot_miss (
      .clk_i(clk_i), .rst_ni(rst_sync_q), .inc_i(miss_inc[c]), .clr_i(clear_i),
      .q_o(tot_miss[c])
    );
    sat_counter #(.CNT_W(CNT_W)) u_win_br (
      .clk_i(clk_i), .rst_ni(rst_sync_q), .inc_i(br_inc[c]), .clr_i(clear_i | win_end),
      .q_o(win_br[c])
    );
    sat_counter #(.CNT_W(CNT_W)) u_win_miss (
      .clk_i(clk_i), .rst_ni(rst_sync_q), .inc_i(miss_inc[c]), .clr_i(clear_i | win_end),
      .q_o(win_miss[c])
    );
  end

  // Snapshot must include the events of the window-closing cycle itself.
  always_comb begin
    snap_br   = '0;
    snap_miss = '0;
    rd_br_d   = '0;
    rd_miss_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      snap_br[c*CNT_W +: CNT_W] = (br_inc[c] && (win_br[c] != {CNT_W{1'b1}}))
                                  ? win_br[c] + CNT_W'(1) : win_br[c];
      snap_miss[c*CNT_W +: CNT_W] = (miss_inc[c] && (win_miss[c] != {CNT_W{1'b1}}))
                                    ? win_miss[c] + CNT_W'(1) : win_miss[c];
      if (rd_ch_i == RD_W'(c)) begin
        rd_br_d   = tot_br[c];
        rd_miss_d = tot_miss[c];
      end
    end
  end

  always_comb begin
    rpt_vld_d = rpt_vld_q;
    if (clear_i)     rpt_vld_d = 1'b0;
    else if (load)   rpt_vld_d = 1'b1;
    else if (accept) rpt_vld_d = 1'b0;

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i && !stop_i && !clear_i) state_d = ST_RUN;
      ST_RUN, ST_HOLD: begin
        if (stop_i && !clear_i) state_d = ST_IDLE;
        else                    state_d = rpt_vld_d ? ST_HOLD : ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q     <= ST_IDLE;
      rpt_vld_q   <= 1'b0;
      rpt_br_q    <= '0;
      rpt_miss_q  <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      tot_br_q    <= '0;
      tot_miss_q  <= '0;
      tot_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      rpt_vld_q   <= rpt_vld_d;
      tot_br_q    <= rd_br_d;
      tot_miss_q  <= rd_miss_d;
      tot_instr_q <= tot_instr;
      if (clear_i) begin
        rpt_br_q   <= '0;
        rpt_miss_q <= '0;
        ovf_q      <= 1'b0;
        err_q      <= 1'b0;
      end else begin
        if (load) begin
          rpt_br_q   <= snap_br;
          rpt_miss_q <= snap_miss;
        end
        if (ovf_set)   ovf_q <= 1'b1;
        if (proto_err) err_q <= 1'b1;
      end
    end
  end

  assign rpt_vld_o   = rpt_vld_q;
  assign rpt_br_o    = rpt_br_q;
  assign rpt_miss_o  = rpt_miss_q;
  assign rpt_ovf_o   = ovf_q;
  assign err_o       = err_q;
  assign tot_br_o    = tot_br_q;
  assign tot_miss_o  = tot_miss_q;
  assign tot_instr_o = tot_instr_q;

endmodule

// File: tb/tb_bp_perf_monitor.sv
// Directed bench for bp_perf_monitor with NUM_CH=2, CNT_W=8, WINDOW=4.
module tb_bp_perf_monitor;
  import bp_perf_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_vld_i;
  logic [1:0]  br_instr_i, br_miss_i;
  logic        start_i, stop_i, clear_i;
  logic [0:0]  rd_ch_i;
  logic [7:0]  tot_br_o, tot_miss_o, tot_instr_o;
  logic        rpt_vld_o, rpt_rdy_i;
  logic [15:0] rpt_br_o, rpt_miss_o;
  logic        rpt_ovf_o, err_o;

  int n_tests = 0;
  int n_fail  = 0;

  bp_perf_monitor #(.NUM_CH(2), .CNT_W(8), .WINDOW(64'd4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_vld_i(instr_vld_i),
    .br_instr_i(br_instr_i), .br_miss_i(br_miss_i),
    .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i), .rd_ch_i(rd_ch_i),
    .tot_br_o(tot_br_o), .tot_miss_o(tot_miss_o), .tot_instr_o(tot_instr_o),
    .rpt_vld_o(rpt_vld_o), .rpt_rdy_i(rpt_rdy_i),
    .rpt_br_o(rpt_br_o), .rpt_miss_o(rpt_miss_o),
    .rpt_ovf_o(rpt_ovf_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [1:0] br, input logic [1:0] ms);
    instr_vld_i = iv;
    br_instr_i  = br;
    br_miss_i   = ms;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, 2'b00, 2'b00);
    start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0;
    rd_ch_i = 1'b0; rpt_rdy_i = 1'b0;
    #2;
    chk("reset_vld", 64'(rpt_vld_o), 64'd0);
    chk("reset_instr", 64'(tot_instr_o), 64'd0);
    chk("reset_err", 64'(err_o), 64'd0);
    repeat (2) cyc();
    rst_ni = 1'b1;
    repeat (3) cyc();

    // First window: ch0 br on 3 retirements, miss on one
    start_i = 1'b1; cyc(); start_i = 1'b0;
    drive(1'b1, 2'b01, 2'b00); cyc();
    drive(1'b1, 2'b01, 2'b01); cyc();
    drive(1'b1, 2'b01, 2'b00); cyc();
    chk("win1_vld_early", 64'(rpt_vld_o), 64'd0);
    drive(1'b1, 2'b00, 2'b00); cyc();
    chk("win1_vld", 64'(rpt_vld_o), 64'd1);
    chk("win1_br", 64'(rpt_br_o), 64'h0003);
    chk("win1_miss", 64'(rpt_miss_o), 64'h0001);
    drive(1'b0, 2'b00, 2'b00); cyc();
    chk("rd_ch0_br", 64'(tot_br_o), 64'd3);
    chk("rd_ch0_miss", 64'(tot_miss_o), 64'd1);
    chk("rd_instr4", 64'(tot_instr_o), 64'd4);

    // Second window ends while the first report is still pending
    drive(1'b1, 2'b10, 2'b10); cyc();
    cyc();
    drive(1'b1, 2'b10, 2'b00); cyc();
    chk("ovf_early", 64'(rpt_ovf_o), 64'd0);
    cyc();
    chk("ovf_set", 64'(rpt_ovf_o), 64'd1);
    chk("ovf_vld", 64'(rpt_vld_o), 64'd1);
    chk("ovf_br_kept", 64'(rpt_br_o), 64'h0003);
    chk("ovf_miss_kept", 64'(rpt_miss_o), 64'h0001);
    drive(1'b0, 2'b00, 2'b00); rd_ch_i = 1'b1; cyc();
    chk("rd_ch1_br", 64'(tot_br_o), 64'd4);
    chk("rd_ch1_miss", 64'(tot_miss_o), 64'd2);
    chk("rd_instr8", 64'(tot_instr_o), 64'd8);

    // Clear takes priority over same-cycle events
    clear_i = 1'b1; drive(1'b1, 2'b11, 2'b00); cyc(); clear_i = 1'b0;
    chk("clr_vld", 64'(rpt_vld_o), 64'd0);
    chk("clr_ovf", 64'(rpt_ovf_o), 64'd0);
    chk("clr_rpt_br", 64'(rpt_br_o), 64'd0);
    chk("clr_state", 64'(dut.state_q), 64'(ST_RUN));
    drive(1'b0, 2'b00, 2'b00); rd_ch_i = 1'b0; cyc();
    chk("clr_tot_br", 64'(tot_br_o), 64'd0);
    chk("clr_tot_instr", 64'(tot_instr_o), 64'd0);

    // Acceptance coinciding with a window end
    drive(1'b1, 2'b01, 2'b00); repeat (4) cyc();
    chk("win3_vld", 64'(rpt_vld_o), 64'd1);
    chk("win3_br", 64'(rpt_br_o), 64'h0004);
    drive(1'b1, 2'b11, 2'b00); repeat (3) cyc();
    drive(1'b1, 2'b11, 2'b11); rpt_rdy_i = 1'b1; cyc();
    chk("same_vld", 64'(rpt_vld_o), 64'd1);
    chk("same_br", 64'(rpt_br_o), 64'h0404);
    chk("same_miss", 64'(rpt_miss_o), 64'h0101);
    chk("same_ovf", 64'(rpt_ovf_o), 64'd0);
    drive(1'b0, 2'b00, 2'b00); cyc();
    chk("accept_vld", 64'(rpt_vld_o), 64'd0);
    chk("accept_state", 64'(dut.state_q), 64'(ST_RUN));
    rpt_rdy_i = 1'b0;

    // Miss without a branch: flagged, not counted
    drive(1'b0, 2'b00, 2'b01); cyc();
    chk("err_set", 64'(err_o), 64'd1);
    drive(1'b0, 2'b00, 2'b00); cyc();
    chk("err_miss_tot", 64'(tot_miss_o), 64'd1);
    chk("err_br_tot", 64'(tot_br_o), 64'd8);

    // Saturation on ch1
    rd_ch_i = 1'b1;
    drive(1'b0, 2'b10, 2'b00); repeat (300) cyc();
    drive(1'b0, 2'b00, 2'b00); cyc();
    chk("sat_ch1_br", 64'(tot_br_o), 64'd255);
    chk("sat_ch1_miss", 64'(tot_miss_o), 64'd1);

    // IDLE ignores events; start+stop resolves as stop
    stop_i = 1'b1; cyc(); stop_i = 1'b0;
    chk("stop_state", 64'(dut.state_q), 64'(ST_IDLE));
    clear_i = 1'b1; cyc(); clear_i = 1'b0;
    chk("idle_clr_err", 64'(err_o), 64'd0);
    rd_ch_i = 1'b0;
    drive(1'b1, 2'b01, 2'b10); repeat (4) cyc();
    chk("idle_err", 64'(err_o), 64'd0);
    chk("idle_vld", 64'(rpt_vld_o), 64'd0);
    drive(1'b0, 2'b00, 2'b00); cyc();
    chk("idle_tot_br", 64'(tot_br_o), 64'd0);
    chk("idle_tot_instr", 64'(tot_instr_o), 64'd0);
    start_i = 1'b1; stop_i = 1'b1; cyc(); start_i = 1'b0; stop_i = 1'b0;
    drive(1'b1, 2'b01, 2'b00); cyc();
    drive(1'b0, 2'b00, 2'b00); cyc();
    chk("startstop_br", 64'(tot_br_o), 64'd0);

    // Asynchronous reset mid-window while HOLD
    start_i = 1'b1; cyc(); start_i = 1'b0;
    drive(1'b1, 2'b01, 2'b00); repeat (4) cyc();
    chk("pre_rst_vld", 64'(rpt_vld_o), 64'd1);
    repeat (2) cyc();
    drive(1'b0, 2'b00, 2'b00); cyc();
    chk("pre_rst_br", 64'(tot_br_o), 64'd6);
    chk("pre_rst_state", 64'(dut.state_q), 64'(ST_HOLD));
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_vld", 64'(rpt_vld_o), 64'd0);
    chk("arst_rpt_br", 64'(rpt_br_o), 64'd0);
    chk("arst_tot_br", 64'(tot_br_o), 64'd0);
    chk("arst_tot_instr", 64'(tot_instr_o), 64'd0);
    chk("arst_state", 64'(dut.state_q), 64'(ST_IDLE));
    repeat (2) cyc();
    rst_ni = 1'b1;
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
